// File: rtl/pipe_stage_ctrl.sv
// Hazard/stall controller for a 5-stage in-order pipeline: derives PC and pipeline-register enables, stage valids and perf counters.
// Enables and mem_req are combinational from current valids; valids/counters update on the next edge; a memory hold freezes everything upstream of MEM/WB.
module pipe_stage_ctrl #(
  parameter int CNT_W  = 16,
  parameter int ZR_IDX = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             mem_is_access,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             v_id,
  output logic             v_ex,
  output logic             v_mem,
  output logic             v_wb,
  output logic             mem_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [4:0] ZR = ZR_IDX[4:0];

  state_t           r_state;
  logic             r_v_id, r_v_ex, r_v_mem, r_v_wb;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_mh, w_br, w_lu, w_stall;

  assign w_mh = r_v_mem & mem_is_access & ~mem_ready;
  assign w_br = r_v_mem & branch_taken & ~w_mh;
  assign w_lu = r_v_ex & ex_is_load & r_v_id & (ex_rd != ZR) &
                ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));
  // A branch squashes the dependent ID instruction, so load-use only stalls when no branch wins.
  assign w_stall = w_mh | (w_lu & ~w_br);

  assign pc_write = rst_n & ~w_stall;
  assign en_ifid  = rst_n & ~w_stall;
  assign en_idex  = rst_n & ~w_mh;
  assign en_exmem = rst_n & ~w_mh;
  assign en_memwb = rst_n;
  assign mem_req  = rst_n & r_v_mem & mem_is_access & (r_state != FLUSH);

  assign v_id      = r_v_id;
  assign v_ex      = r_v_ex;
  assign v_mem     = r_v_mem;
  assign v_wb      = r_v_wb;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_v_id      <= 1'b0;
      r_v_ex      <= 1'b0;
      r_v_mem     <= 1'b0;
      r_v_wb      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_mh) begin
        r_v_wb  <= 1'b0;
        r_state <= MEM_WAIT;
      end else if (w_br) begin
        r_v_id  <= 1'b0;
        r_v_ex  <= 1'b0;
        r_v_mem <= 1'b0;
        r_v_wb  <= 1'b1;
        r_state <= FLUSH;
      end else if (w_lu) begin
        r_v_ex  <= 1'b0;
        r_v_mem <= r_v_ex;
        r_v_wb  <= r_v_mem;
        r_state <= RUN;
      end else begin
        // The fetch slot behind a taken branch is wrong-path, so it is discarded for one cycle.
        r_v_id  <= fetch_valid & (r_state != FLUSH);
        r_v_ex  <= r_v_id;
        r_v_mem <= r_v_ex;
        r_v_wb  <= r_v_mem;
        r_state <= RUN;
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br && (r_flush_cnt != '1))    r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed table-driven bench for pipe_stage_ctrl, plus hand sequences for reset-in-wait and counter saturation.
module tb_pipe_stage_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_valid;
  logic [4:0]    id_rs1, id_rs2;
  logic          id_use1, id_use2;
  logic          ex_is_load;
  logic [4:0]    ex_rd;
  logic          mem_is_access, mem_ready, branch_taken;
  logic          pc_write, en_ifid, en_idex, en_exmem, en_memwb;
  logic          v_id, v_ex, v_mem, v_wb, mem_req;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_ctrl #(.CNT_W(CW), .ZR_IDX(31)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .mem_is_access(mem_is_access),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_write(pc_write), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
    .mem_req(mem_req), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // cmb = {pc_write,en_ifid,en_idex,en_exmem,en_memwb,mem_req} before the edge
  // vld = {v_id,v_ex,v_mem,v_wb} after the edge
  typedef struct {
    logic       fv;
    logic [4:0] rs1, rs2;
    logic       u1, u2, ld;
    logic [4:0] rd;
    logic       acc, rdy, br;
    logic [5:0] cmb;
    logic [3:0] vld;
    int         sc, fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic fv, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic ld,
                              input logic [4:0] rd, input logic acc, input logic rdy,
                              input logic br, input logic [5:0] cmb, input logic [3:0] vld,
                              input int sc, input int fc);
    vec_t v;
    v.fv = fv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ld = ld;
    v.rd = rd; v.acc = acc; v.rdy = rdy; v.br = br;
    v.cmb = cmb; v.vld = vld; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  function automatic vec_t adv(input logic [3:0] vld, input int sc, input int fc);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111110, vld, sc, fc);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    fetch_valid = v.fv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use1 = v.u1; id_use2 = v.u2;
    ex_is_load = v.ld; ex_rd = v.rd; mem_is_access = v.acc; mem_ready = v.rdy; branch_taken = v.br;
    @(negedge clk);
    chk("enables", idx, 32'({pc_write, en_ifid, en_idex, en_exmem, en_memwb, mem_req}), 32'(v.cmb));
    @(posedge clk); #1;
    chk("valids", idx, 32'({v_id, v_ex, v_mem, v_wb}), 32'(v.vld));
    chk("stall_cnt", idx, 32'(stall_cnt), 32'(v.sc));
    chk("flush_cnt", idx, 32'(flush_cnt), 32'(v.fc));
  endtask

  initial begin
    rst_n = 1'b1;
    fetch_valid = 1; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
    ex_is_load = 0; ex_rd = 0; mem_is_access = 1; mem_ready = 0; branch_taken = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_enables", 0, 32'({pc_write, en_ifid, en_idex, en_exmem, en_memwb, mem_req}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids", 0, 32'({v_id, v_ex, v_mem, v_wb}), 32'd0);
    chk("rst_counters", 0, 32'({stall_cnt, flush_cnt}), 32'd0);
    rst_n = 1'b1;

    // fill pipeline
    tbl.push_back(adv(4'b1000, 0, 0));
    tbl.push_back(adv(4'b1100, 0, 0));
    tbl.push_back(adv(4'b1110, 0, 0));
    tbl.push_back(adv(4'b1111, 0, 0));
    // load-use on rs1, then the load has left EX
    tbl.push_back(mk(1, 5, 0, 1, 0, 1, 5, 0, 1, 0, 6'b001110, 4'b1011, 1, 0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 1, 5, 0, 1, 0, 6'b111110, 4'b1101, 1, 0));
    // zero register is never a hazard
    tbl.push_back(mk(1, 31, 0, 1, 0, 1, 31, 0, 1, 0, 6'b111110, 4'b1110, 1, 0));
    // load-use on rs2
    tbl.push_back(mk(1, 0, 7, 0, 1, 1, 7, 0, 1, 0, 6'b001110, 4'b1011, 2, 0));
    tbl.push_back(adv(4'b1101, 2, 0));
    // matching registers but not used
    tbl.push_back(mk(1, 7, 7, 0, 0, 1, 7, 0, 1, 0, 6'b111110, 4'b1110, 2, 0));
    // store waits three cycles; mid-wait also carries a load-use that must lose
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011, 4'b1110, 3, 0));
    tbl.push_back(mk(1, 3, 0, 1, 0, 1, 3, 1, 0, 0, 6'b000011, 4'b1110, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011, 4'b1110, 5, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b111111, 4'b1111, 5, 0));
    // taken branch, flush cycle, then refill
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b111110, 4'b0001, 5, 1));
    tbl.push_back(adv(4'b0000, 5, 1));
    tbl.push_back(adv(4'b1000, 5, 1));
    tbl.push_back(adv(4'b1100, 5, 1));
    tbl.push_back(adv(4'b1110, 5, 1));
    // branch coinciding with load-use: branch only, no stall count
    tbl.push_back(mk(1, 5, 0, 1, 0, 1, 5, 0, 1, 1, 6'b111110, 4'b0001, 5, 2));
    tbl.push_back(adv(4'b0000, 5, 2));
    tbl.push_back(adv(4'b1000, 5, 2));
    tbl.push_back(adv(4'b1100, 5, 2));
    tbl.push_back(adv(4'b1110, 5, 2));
    // memory hold beats a taken branch
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b000011, 4'b1110, 6, 2));

    foreach (tbl[i]) run_vec(tbl[i], i + 1);

    // reset pulse while in MEM_WAIT
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_memreq", 100, 32'(mem_req), 32'd0);
    chk("rst_mid_enables", 100, 32'({pc_write, en_ifid, en_idex, en_exmem, en_memwb}), 32'd0);
    chk("rst_mid_valids", 100, 32'({v_id, v_ex, v_mem, v_wb}), 32'd0);
    chk("rst_mid_counters", 100, 32'({stall_cnt, flush_cnt}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111110, 4'b1000, 0, 0), 101);
    run_vec(adv(4'b1100, 0, 0), 102);
    run_vec(adv(4'b1110, 0, 0), 103);

    // long memory hold saturates the stall counter
    for (int k = 0; k < 20; k++)
      run_vec(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011, 4'b1110, (k + 1 > 15) ? 15 : k + 1, 0), 200 + k);
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b111111, 4'b1111, 15, 0), 220);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
